bram_tdp_responder: RTL and testbench

BRAM_TDP_RESPONDER -- requirements
Module: bram_tdp_responder

---
 rtl/bram_tdp_pkg.sv | 12 +
 rtl/bram_tdp_clear_ctrl.sv | 49 ++++
 rtl/bram_tdp_responder.sv | 82 ++++++++
 tb/tb_bram_tdp_responder.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bram_tdp_pkg.sv
// Shared types and default geometry for the true-dual-port BRAM responder.
package bram_tdp_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } clr_state_t;

    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_DATA_WIDTH = 32;

endpackage

// File: rtl/bram_tdp_clear_ctrl.sv
// Post-reset clear sequencer: walks every address once, writing zero, then parks in READY.
module bram_tdp_clear_ctrl
    import bram_tdp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    output logic [ADDR_WIDTH-1:0] clr_addr,
    output logic                  clr_we
);

    clr_state_t state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= CLEAR;
            clr_addr  <= '0;
            init_busy <= 1'b1;
            clr_we    <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    // The edge that clears the last word also hands over to READY.
                    if (clr_addr == {ADDR_WIDTH{1'b1}}) begin
                        state     <= READY;
                        init_busy <= 1'b0;
                        clr_we    <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                READY: begin
                    state     <= READY;
                    init_busy <= 1'b0;
                    clr_we    <= 1'b0;
                end
                default: begin
                    state     <= CLEAR;
                    clr_addr  <= '0;
                    init_busy <= 1'b1;
                    clr_we    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/bram_tdp_responder.sv
// True-dual-port read-first BRAM with post-reset zero clear; port A wins write collisions.
// Optional collision flag compiled in by BRAM_TDP_COLLISION_DET_EN.
module bram_tdp_responder
    import bram_tdp_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  init_busy,
    input  logic                  rce_a,
    input  logic [ADDR_WIDTH-1:0] ra_a,
    output logic [DATA_WIDTH-1:0] rq_a,
    input  logic                  wce_a,
    input  logic [ADDR_WIDTH-1:0] wa_a,
    input  logic [DATA_WIDTH-1:0] wd_a,
    input  logic                  rce_b,
    input  logic [ADDR_WIDTH-1:0] ra_b,
    output logic [DATA_WIDTH-1:0] rq_b,
    input  logic                  wce_b,
    input  logic [ADDR_WIDTH-1:0] wa_b,
    input  logic [DATA_WIDTH-1:0] wd_b,
    output logic                  collision
);

    localparam int DEPTH = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic                  clr_we;

    bram_tdp_clear_ctrl #(.ADDR_WIDTH(ADDR_WIDTH)) u_clear (
        .clk       (clk),
        .rst       (rst),
        .init_busy (init_busy),
        .clr_addr  (clr_addr),
        .clr_we    (clr_we)
    );

    // Port A is assigned last so it overrides port B on a same-address write.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_addr] <= '0;
        end else if (!init_busy) begin
            if (wce_b) mem[wa_b] <= wd_b;
            if (wce_a) mem[wa_a] <= wd_a;
        end
    end

    // Reads sample the array before this edge's writes land, giving read-first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rq_a <= '0;
            rq_b <= '0;
        end else if (init_busy) begin
            rq_a <= '0;
            rq_b <= '0;
        end else begin
            if (rce_a) rq_a <= mem[ra_a];
            if (rce_b) rq_b <= mem[ra_b];
        end
    end

`ifdef BRAM_TDP_COLLISION_DET_EN
    logic col_hit;

    always_comb begin
        col_hit = (wce_a && wce_b && (wa_a == wa_b)) ||
                  (wce_a && rce_b && (wa_a == ra_b)) ||
                  (wce_b && rce_a && (wa_b == ra_a));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) collision <= 1'b0;
        else     collision <= col_hit && !init_busy;
    end
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_bram_tdp_responder.sv
// Directed + randomized bench for bram_tdp_responder against an array-based reference model.
module tb_bram_tdp_responder;

    localparam int AW    = 9;
    localparam int DW    = 32;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          init_busy;
    logic          rce_a = 0, rce_b = 0, wce_a = 0, wce_b = 0;
    logic [AW-1:0] ra_a = '0, ra_b = '0, wa_a = '0, wa_b = '0;
    logic [DW-1:0] wd_a = '0, wd_b = '0;
    logic [DW-1:0] rq_a, rq_b;
    logic          collision;

    int checks = 0;
    int failures = 0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_rqa, exp_rqb;
    logic          exp_col;
    int            clear_left;

    always #5 clk = ~clk;

    bram_tdp_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .init_busy(init_busy),
        .rce_a(rce_a), .ra_a(ra_a), .rq_a(rq_a),
        .wce_a(wce_a), .wa_a(wa_a), .wd_a(wd_a),
        .rce_b(rce_b), .ra_b(ra_b), .rq_b(rq_b),
        .wce_b(wce_b), .wa_b(wa_b), .wd_b(wd_b),
        .collision(collision)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return DW'(32'h55000 | a | (a << 20));
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rce_a = 0; rce_b = 0; wce_a = 0; wce_b = 0;
    endtask

    // Model of one clock: memory is all-zero once the clear is done; during the
    // clear all port traffic is discarded and read data stays zero.
    task automatic step();
        logic [DW-1:0] na, nb;
        logic          nc;
        na = exp_rqa; nb = exp_rqb; nc = 1'b0;
        if (clear_left > 0) begin
            clear_left--;
            na = '0; nb = '0;
        end else begin
            if (rce_a) na = ref_mem[ra_a];
            if (rce_b) nb = ref_mem[ra_b];
`ifdef BRAM_TDP_COLLISION_DET_EN
            nc = (wce_a && wce_b && wa_a == wa_b) ||
                 (wce_a && rce_b && wa_a == ra_b) ||
                 (wce_b && rce_a && wa_b == ra_a);
`endif
            if (wce_b) ref_mem[wa_b] = wd_b;
            if (wce_a) ref_mem[wa_a] = wd_a;
        end
        exp_rqa = na; exp_rqb = nb; exp_col = nc;
        @(posedge clk);
        @(negedge clk);
        chk("rq_a", rq_a, exp_rqa);
        chk("rq_b", rq_b, exp_rqb);
        chk("collision", DW'(collision), DW'(exp_col));
        chk("init_busy", DW'(init_busy), DW'(clear_left > 0));
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        exp_rqa = '0; exp_rqb = '0; exp_col = 1'b0;
        clear_left = DEPTH;
    endtask

    // Asserts rst between edges, checks the outputs respond without a clock, then releases.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk({tag, "_rq_a"}, rq_a, '0);
        chk({tag, "_rq_b"}, rq_b, '0);
        chk({tag, "_col"}, DW'(collision), '0);
        chk({tag, "_busy"}, DW'(init_busy), 1);
        idle();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Runs the clear to completion, optionally poking a write to 0x005 mid-clear.
    task automatic run_clear(input string tag, input bit poke);
        int n;
        n = 0;
        do begin
            idle();
            rce_a = 1'($urandom); ra_a = AW'($urandom);
            rce_b = 1'($urandom); ra_b = AW'($urandom);
            if (poke && n == 5) begin
                wce_a = 1; wa_a = 9'h005; wd_a = 32'hFFFF_FFFF;
                wce_b = 1; wa_b = 9'h006; wd_b = 32'h1234_5678;
            end
            step();
            n++;
        end while (init_busy === 1'b1 && n < 1000);
        chk(tag, DW'(n), DW'(DEPTH));
        idle();
    endtask

    initial begin
        idle();
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_rq_a", rq_a, '0);
        chk("rst_rq_b", rq_b, '0);
        chk("rst_col", DW'(collision), '0);
        chk("rst_busy", DW'(init_busy), 1);
        rst = 1'b0;

        run_clear("clear_len", 1'b1);

        // Cleared words read zero, including ones written during the clear.
        rce_a = 1; ra_a = 9'h1FF; rce_b = 1; ra_b = 9'h005;
        step();
        chk("rd_1ff", rq_a, '0);
        chk("rd_005", rq_b, '0);
        idle();

        // Split-half pattern fill, then each port reads its own half.
        for (int i = 0; i < 256; i++) begin
            wce_a = 1; wa_a = AW'(i);       wd_a = pat(i);
            wce_b = 1; wa_b = AW'(i + 256); wd_b = pat(i + 256);
            step();
        end
        idle();
        for (int i = 0; i < 256; i++) begin
            rce_a = 1; ra_a = AW'(i);
            rce_b = 1; ra_b = AW'(i + 256);
            step();
            if (i % 32 == 0) begin
                chk("pat_a", rq_a, pat(i));
                chk("pat_b", rq_b, pat(i + 256));
            end
        end
        idle();

        // Same-address double write: port A wins.
        wce_a = 1; wa_a = 9'h010; wd_a = 32'hAAAA_0001;
        wce_b = 1; wa_b = 9'h010; wd_b = 32'hBBBB_0002;
        step();
        idle();
        rce_a = 1; ra_a = 9'h010;
        step();
        chk("ww_a_wins", rq_a, 32'hAAAA_0001);
        idle();

        // Cross-port read-first.
        wce_a = 1; wa_a = 9'h020; wd_a = 32'h1;
        step();
        wce_a = 1; wa_a = 9'h020; wd_a = 32'h2;
        rce_b = 1; ra_b = 9'h020;
        step();
        chk("rf_old", rq_b, 32'h1);
        idle();
        rce_b = 1; ra_b = 9'h020;
        step();
        chk("rf_new", rq_b, 32'h2);
        idle();

        // Random traffic on a narrow address window to provoke collisions.
        for (int i = 0; i < 400; i++) begin
            rce_a = 1'($urandom); ra_a = AW'($urandom_range(0, 15));
            rce_b = 1'($urandom); ra_b = AW'($urandom_range(0, 15));
            wce_a = 1'($urandom); wa_a = AW'($urandom_range(0, 15)); wd_a = $urandom;
            wce_b = 1'($urandom); wa_b = AW'($urandom_range(0, 15)); wd_b = $urandom;
            step();
        end

        // Reset mid-traffic with non-zero read data held.
        idle();
        rce_a = 1; ra_a = 9'h010; rce_b = 1; ra_b = 9'h020;
        step();
        async_reset("rst_traffic");

        // Reset again at clear count 100; the full clear must restart.
        for (int i = 0; i < 100; i++) step();
        async_reset("rst_midclear");
        run_clear("clear_restart", 1'b0);

        rce_a = 1; ra_a = 9'h010; rce_b = 1; ra_b = 9'h0FF;
        step();
        chk("post_rst_a", rq_a, '0);
        chk("post_rst_b", rq_b, '0);
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
